// File: rtl/micro_op_ring_queue.sv
// micro_op_ring_queue
//   Circular micro-op queue between fetch/expansion and decode/issue.
//   Each cycle it accepts a bundle of up to IN_N slots, packs the valid slots
//   in ascending slot order, exposes the oldest OUT_N entries and retires
//   0..OUT_N of them.
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     flush        discard all contents on the next edge
//     stall        freeze: no push, no pop (in_ready still tracks free space)
//     in_valid     bundle present
//     in_slot_vld  per-slot valid, bit k qualifies slot k
//     in_data      slot k at [k*PAYLOAD_W +: PAYLOAD_W]
//     in_ready     bundle fits in the free space (occupancy before any pop)
//     out_vld      bit i: head entry i is valid
//     out_data     head entry i, the oldest entry is i=0 (zero when invalid)
//     out_pop      number of head entries retired (clamped)
//     count        current occupancy
//
//   Optional feature macro: DEC_Q_BYPASS_EN
//     When defined, a bundle pushed into an empty queue is visible on out_*
//     in the same cycle and can be retired at once without being written.
module micro_op_ring_queue #(
    parameter int PAYLOAD_W = 128,
    parameter int IN_N      = 4,
    parameter int DEPTH     = 8,
    parameter int OUT_N     = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int POP_W    = $clog2(OUT_N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    input  logic [IN_N-1:0]            in_slot_vld,
    input  logic [IN_N*PAYLOAD_W-1:0]  in_data,
    output logic                       in_ready,
    output logic [OUT_N-1:0]           out_vld,
    output logic [OUT_N*PAYLOAD_W-1:0] out_data,
    input  logic [POP_W-1:0]           out_pop,
    output logic [CNT_W-1:0]           count
);

`ifdef DEC_Q_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int CMP_N = (IN_N > OUT_N) ? IN_N : OUT_N;

    // (p + inc) mod DEPTH for p < DEPTH and inc <= DEPTH; works for any DEPTH.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = (CNT_W+1)'(p) + (CNT_W+1)'(inc);
        if (s >= (CNT_W+1)'(DEPTH))
            s = s - (CNT_W+1)'(DEPTH);
        return PTR_W'(s);
    endfunction

    // min(req, avail, OUT_N): oversized pop requests saturate silently.
    function automatic logic [POP_W-1:0] clamp_pop(input logic [POP_W-1:0] req,
                                                   input logic [CNT_W-1:0] avail);
        logic [CNT_W:0] lim;
        lim = (CNT_W+1)'(OUT_N);
        if ((CNT_W+1)'(avail) < lim) lim = (CNT_W+1)'(avail);
        if ((CNT_W+1)'(req) < lim)   lim = (CNT_W+1)'(req);
        return POP_W'(lim);
    endfunction

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     n_in;
    logic [CNT_W-1:0]     rank [IN_N];
    logic [PAYLOAD_W-1:0] comp [CMP_N];
    logic                 push, byp_act;
    logic [POP_W-1:0]     n_pop;
    logic [CNT_W-1:0]     skip, pushed;

    // Slot k goes to compacted position rank[k] = number of valid slots below it.
    always_comb begin
        n_in = '0;
        for (int k = 0; k < IN_N; k++) begin
            rank[k] = n_in;
            if (in_slot_vld[k])
                n_in = n_in + CNT_W'(1);
        end
    end

    always_comb begin
        for (int j = 0; j < CMP_N; j++)
            comp[j] = '0;
        for (int k = 0; k < IN_N; k++)
            if (in_slot_vld[k])
                comp[rank[k]] = in_data[k*PAYLOAD_W +: PAYLOAD_W];
    end

    assign in_ready = (CNT_W'(DEPTH) - count) >= n_in;
    assign push     = in_valid & in_ready & ~stall & ~flush & ~rst;
    // With an empty queue head == tail, so bypassed slots are simply skipped.
    assign byp_act  = BYP && (count == '0) && push;
    assign n_pop    = (stall | flush | rst) ? '0
                    : clamp_pop(out_pop, byp_act ? n_in : count);
    assign skip     = byp_act ? CNT_W'(n_pop) : '0;
    assign pushed   = push ? n_in : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (!stall) begin
            head  <= wrap_add(head, byp_act ? '0 : CNT_W'(n_pop));
            if (push)
                tail <= wrap_add(tail, n_in - skip);
            count <= count + pushed - CNT_W'(n_pop);
        end
    end

    // Payload storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < IN_N; k++)
                if (in_slot_vld[k] && (rank[k] >= skip))
                    mem[wrap_add(tail, rank[k] - skip)] <= in_data[k*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    always_comb begin
        out_vld  = '0;
        out_data = '0;
        for (int i = 0; i < OUT_N; i++) begin
            if (count > CNT_W'(i)) begin
                out_vld[i] = 1'b1;
                out_data[i*PAYLOAD_W +: PAYLOAD_W] = mem[wrap_add(head, CNT_W'(i))];
            end else if (byp_act && (n_in > CNT_W'(i))) begin
                out_vld[i] = 1'b1;
                out_data[i*PAYLOAD_W +: PAYLOAD_W] = comp[i];
            end
        end
    end

endmodule

// File: tb/tb_micro_op_ring_queue.sv
// Directed bench for micro_op_ring_queue at default parameters
// (PAYLOAD_W=128, IN_N=4, DEPTH=8, OUT_N=2).
module tb_micro_op_ring_queue;

    logic         clk = 1'b0;
    logic         rst, flush, stall, in_valid;
    logic [3:0]   in_slot_vld;
    logic [511:0] in_data;
    logic         in_ready;
    logic [1:0]   out_vld;
    logic [255:0] out_data;
    logic [1:0]   out_pop;
    logic [3:0]   count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    micro_op_ring_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_slot_vld(in_slot_vld), .in_data(in_data),
        .in_ready(in_ready), .out_vld(out_vld), .out_data(out_data),
        .out_pop(out_pop), .count(count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_slot_vld = 4'b0000; in_data = '0; out_pop = 2'd0;
    endtask

    task automatic drive(input logic [3:0] sv, input logic [127:0] d0, input logic [127:0] d1,
                         input logic [127:0] d2, input logic [127:0] d3, input logic [1:0] pop);
        in_valid = 1'b1; in_slot_vld = sv; in_data = {d3, d2, d1, d0}; out_pop = pop;
    endtask

    task automatic pop_only(input logic [1:0] pop);
        out_pop = pop;
    endtask

    // Apply the current inputs for one edge, then return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    function automatic logic [127:0] o0();
        return out_data[127:0];
    endfunction
    function automatic logic [127:0] o1();
        return out_data[255:128];
    endfunction

    localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

    initial begin
        idle();
        rst = 1'b1;
        #1;
        cyc();
        check("rst_count", 128'(count), 128'd0);
        check("rst_vld", 128'(out_vld), 128'd0);
        check("rst_ready", 128'(in_ready), 128'd1);
        check("rst_data", 128'(out_data), 128'd0);

        // Compaction of slots 1 and 3
        drive(4'b1010, JUNK, 128'hA, JUNK, 128'hB, 2'd0);
        cyc();
        check("cmp_count", 128'(count), 128'd2);
        check("cmp_vld", 128'(out_vld), 128'b11);
        check("cmp_d0", o0(), 128'hA);
        check("cmp_d1", o1(), 128'hB);

        // Empty-bundle push changes nothing
        drive(4'b0000, JUNK, JUNK, JUNK, JUNK, 2'd0);
        cyc();
        check("empty_push_count", 128'(count), 128'd2);

        // Fill to 8, then a 1-slot bundle with pop=2 must be refused
        drive(4'b1111, 128'hC, 128'hD, 128'hE, 128'hF, 2'd0);
        cyc();
        drive(4'b0011, 128'h10, 128'h11, JUNK, JUNK, 2'd0);
        cyc();
        check("full_count", 128'(count), 128'd8);
        drive(4'b0001, 128'h99, JUNK, JUNK, JUNK, 2'd2);
        #1;
        check("full_ready", 128'(in_ready), 128'd0);
        cyc();
        check("full_pop_count", 128'(count), 128'd6);
        check("full_pop_d0", o0(), 128'hC);
        check("full_pop_d1", o1(), 128'hD);

        // Wrap: six single pushes, five pops, then a 4-slot bundle at 6,7,0,1
        rst = 1'b1;
        cyc();
        for (int n = 0; n < 6; n++) begin
            drive(4'b0001, 128'(32'h20 + n), JUNK, JUNK, JUNK, 2'd0);
            cyc();
        end
        pop_only(2'd2); cyc();
        pop_only(2'd2); cyc();
        pop_only(2'd1); cyc();
        check("wrap_pre_count", 128'(count), 128'd1);
        check("wrap_pre_d0", o0(), 128'h25);
        drive(4'b1111, 128'h30, 128'h31, 128'h32, 128'h33, 2'd0);
        cyc();
        check("wrap_count", 128'(count), 128'd5);
        check("wrap_d0", o0(), 128'h25);
        check("wrap_d1", o1(), 128'h30);
        pop_only(2'd2); cyc();
        check("wrap_p1_d0", o0(), 128'h31);
        check("wrap_p1_d1", o1(), 128'h32);
        pop_only(2'd2); cyc();
        check("wrap_p2_vld", 128'(out_vld), 128'b01);
        check("wrap_p2_d0", o0(), 128'h33);
        check("wrap_p2_d1", o1(), 128'h0);

        // Over-request pop with count=1
        pop_only(2'd2); cyc();
        check("clamp_count", 128'(count), 128'd0);
        check("clamp_vld", 128'(out_vld), 128'd0);

        // Stall freezes push and pop, in_ready still reports space
        drive(4'b0011, 128'h40, 128'h41, JUNK, JUNK, 2'd0);
        cyc();
        stall = 1'b1;
        drive(4'b0001, 128'h42, JUNK, JUNK, JUNK, 2'd1);
        #1;
        check("stall_ready", 128'(in_ready), 128'd1);
        cyc();
        check("stall_count", 128'(count), 128'd2);
        check("stall_d0", o0(), 128'h40);
        check("stall_d1", o1(), 128'h41);

        // Flush at count=5 beats a simultaneous push and pop
        drive(4'b0111, 128'h50, 128'h51, 128'h52, JUNK, 2'd0);
        cyc();
        check("pre_flush_count", 128'(count), 128'd5);
        flush = 1'b1;
        drive(4'b0111, 128'h60, 128'h61, 128'h62, JUNK, 2'd1);
        cyc();
        check("flush_count", 128'(count), 128'd0);
        check("flush_vld", 128'(out_vld), 128'd0);
        check("flush_ready", 128'(in_ready), 128'd1);

        // Reset mid-stream
        drive(4'b1111, 128'h70, 128'h71, 128'h72, 128'h73, 2'd0);
        cyc();
        rst = 1'b1;
        drive(4'b0011, 128'h74, 128'h75, JUNK, JUNK, 2'd1);
        cyc();
        check("midrst_count", 128'(count), 128'd0);
        check("midrst_vld", 128'(out_vld), 128'd0);

        // Push X,Y,Z into an empty queue with pop=2
        drive(4'b0111, 128'h80, 128'h81, 128'h82, JUNK, 2'd2);
        #1;
`ifdef DEC_Q_BYPASS_EN
        check("byp_same_vld", 128'(out_vld), 128'b11);
        check("byp_same_d0", o0(), 128'h80);
        check("byp_same_d1", o1(), 128'h81);
        cyc();
        check("byp_next_count", 128'(count), 128'd1);
        check("byp_next_d0", o0(), 128'h82);
`else
        check("byp_same_vld", 128'(out_vld), 128'b00);
        cyc();
        check("byp_next_count", 128'(count), 128'd3);
        check("byp_next_d0", o0(), 128'h80);
        check("byp_next_d1", o1(), 128'h81);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/micro_op_ring_queue.md
Name: micro_op_ring_queue

Overview:
- Parametrised successor to the front-end decode queue.
- Circular buffer between fetch/micro-op expansion and the decode/issue stage.
- Accepts a bundle of up to IN_N micro-op slots per cycle, each with its own slot-valid bit, and compacts the valid slots in ascending slot order.
- Exposes the oldest OUT_N entries and retires 0..OUT_N of them per cycle; back-pressures fetch through in_ready.

Parameters:
- PAYLOAD_W, 128: bits per entry (opcode, register addresses, immediate, bit mode, eflags mode, pc, packed by the producer).
- IN_N, 4: input slots per bundle.
- DEPTH, 8: entries; DEPTH >= IN_N and DEPTH >= OUT_N; need not be a power of two.
- OUT_N, 2: head entries exposed per cycle.
- PTR_W, $clog2(DEPTH): pointer width (derived).
- CNT_W, $clog2(DEPTH+1): occupancy width (derived).
- POP_W, $clog2(OUT_N+1): pop-count width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all contents (branch mispredict or exception).
- stall  in  1  freeze: no push, no pop.
- in_valid  in  1  bundle present.
- in_slot_vld  in  IN_N  per-slot valid; bit k qualifies slot k.
- in_data  in  IN_N*PAYLOAD_W  slot k at bits [k*PAYLOAD_W +: PAYLOAD_W].
- in_ready  out  1  bundle can be accepted this cycle.
- out_vld  out  OUT_N  bit i: head entry i is valid.
- out_data  out  OUT_N*PAYLOAD_W  head entry i; the oldest entry is i=0.
- out_pop  in  POP_W  number of head entries retired this cycle.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=1 at the edge): head=0, tail=0, count=0. Outputs then read out_vld=0, count=0, in_ready=1 and out_data=0.
- Signal priority per edge: rst > flush > stall > normal operation.
- flush: same effect as reset on the next edge. Any bundle or pop in that cycle is ignored.
- n_in = popcount(in_slot_vld).
- in_ready = (DEPTH - count) >= n_in.
  - Uses occupancy before any pop; there is no combinational path from out_pop to in_ready.
  - Depends on in_slot_vld; producers must not gate in_slot_vld on in_ready.
- push = in_valid & in_ready & ~stall & ~flush & ~rst.
  - A push with n_in=0 is legal and changes nothing.
- Compaction: the j-th set bit of in_slot_vld (ascending) is written to entry (tail + j) mod DEPTH. On push, tail <= (tail + n_in) mod DEPTH.
- Pop: n_pop = min(out_pop, count, OUT_N); an excess request is clamped, not an error. head <= (head + n_pop) mod DEPTH; gated by stall, flush and rst.
- Occupancy: count <= count + (push ? n_in : 0) - n_pop.
  - Push and pop in the same cycle are both honoured.
  - With count=DEPTH and a pop pending, in_ready is still 0.
- Head view:
  - out_vld[i] = (count > i).
  - out_data[i] = entry[(head + i) mod DEPTH] when valid, else 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle).
- Wrap-around: all index arithmetic is modulo DEPTH, computed without power-of-two truncation.
- Ordering: FIFO order is preserved across bundles and within a bundle by slot index.
- stall held: all state, including out_*, holds; in_ready still reflects free space.

Optional Feature:
- Macro: DEC_Q_BYPASS_EN.
- Defined, when count=0 and push occurs:
  - out_vld and out_data show the first min(n_in, OUT_N) compacted input slots combinationally in the same cycle.
  - out_pop may retire them, with n_pop clamped to min(n_in, OUT_N).
  - Only the remaining n_in - n_pop entries are written; tail and count advance by that amount.
- Undefined: no combinational path from in_* to out_*. When count=0, out_vld=0 and pops are clamped to 0.

Test Plan:
- Reset, then in_valid=1, in_slot_vld=4'b1010, data A (slot1), B (slot3) -> next cycle count=2, out_vld=2'b11, out_data[0]=A, out_data[1]=B.
- Fill to count=8, present in_slot_vld=4'b0001 with out_pop=2 -> in_ready=0; next cycle count=6, head advanced by 2, no write.
- Wrap: 6 single-slot pushes, 5 pops, then 4-slot push -> entries land at indices 6,7,0,1; out_data order remains FIFO; count=5.
- out_pop=2 with count=1 -> n_pop=1, next cycle count=0, out_vld=0; stall=1 with push and pop presented -> count and pointers unchanged.
- flush=1 with push of 3 slots and out_pop=1 at count=5 -> next cycle count=0, out_vld=0, in_ready=1; rst=1 mid-stream gives the same result.
- DEC_Q_BYPASS_EN: count=0, push 3 slots (X,Y,Z), out_pop=2 -> same cycle out_data[0]=X, out_data[1]=Y; next cycle count=1, out_data[0]=Z. Without the macro, the same stimulus gives out_vld=0 and next cycle count=3.
